factorial_ctrl: RTL and testbench
=================================

# factorial_ctrl

Moore FSM controller that sequences the 16-bit factorial datapath: register file with result register S0 and counter register S1, multiplier, decrement adder and two 3:1 write muxes. On a START pulse it loads N and an initial product of 1, then loops multiply/decrement until the counter reaches 1, and signals DONE. It sits between the top-level command interface and the datapath. Its only datapath status input is the adder output SUM, which equals S1 − 1.

## Interface
Parameters:
- none; all encodings are constants in the shared package.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  synchronous, active-high reset
- START  input  1  start request; sampled only in IDLE
- N_IN  input  16  operand N; the same value the top drives to the datapath DATA_IN2
- SUM  input  16  datapath S1 − 1
- WE1  output  1  write enable, S0 port
- WE2  output  1  write enable, S1 port
- WA1  output  1  S0 write address
- WA2  output  2  S1 write address
- REA1  output  1  read enable A
- REA2  output  1  read enable B
- SEL_MUX1  output  2  mux1 select: 0 = const 0, 1 = MUL, 2 = const 1
- SEL_MUX2  output  2  mux2 select: 0 = DATA_IN2, 1 = SUM, 2 = const 0
- BUSY  output  1  high in every state except IDLE
- DONE  output  1  one-cycle completion pulse
- ERR  output  1  one-cycle reject pulse, coincident with DONE

## Operation
States:
- IDLE
  - All enables 0.
  - START=1 → LOAD.
- LOAD
  - WE1=1, SEL_MUX1=2, so S0 ← 1.
  - WE2=1, SEL_MUX2=0, so S1 ← N_IN.
  - Next state: CHECK.
- CHECK
  - REA1=REA2=1; no writes.
  - SUM==16'h0000 (N=1) or SUM==16'hFFFF (N=0) → FIN.
  - Otherwise → MULT.
- MULT
  - REA1=REA2=1.
  - WE1=1, SEL_MUX1=1, so S0 ← S0×S1.
  - WE2=1, SEL_MUX2=1, so S1 ← S1−1.
  - Both writes occur on the same edge.
  - Next state: CHECK.
- FIN
  - DONE=1 for one cycle.
  - S0 holds N! (0! = 1).
  - Next state: IDLE.

General rules:
- WA1 is always 1'b0 (S0); WA2 is always 2'b00 (S1).
- In any state with its WE low, each SEL_MUX output drives 0.
- Outputs are decoded combinationally from the state register only (Moore); there are no combinational paths from inputs to outputs.
- START in any state other than IDLE is ignored. A START held high across FIN→IDLE begins a new run.
- Multiplication wraps modulo 2^16; no saturation.
- Arithmetic correctness is owned by the datapath. The controller trusts SUM.

## Timing
- Reset values: state=IDLE; every output 0.
- RST asserted mid-run: IDLE on the next edge, all WE low from that cycle on. S0/S1 contents are not cleared.
- Latency, counted from the START sample edge to the first DONE cycle:
  - N ≤ 1: 3 cycles (LOAD, CHECK, FIN).
  - N ≥ 2: 2(N−1) + 3 cycles.
- DONE and ERR are never asserted in the same cycle as any WE.
- BUSY goes high the cycle after START is sampled, and low the cycle after FIN.

## Configuration
- Macro: FACT_OVF_CHECK_EN.
- Defined:
  - In IDLE, START with N_IN > 8 goes directly to REJ instead of LOAD.
  - REJ drives DONE=1 and ERR=1 for one cycle with no writes, then returns to IDLE.
  - Reject latency is 1 cycle.
  - Rationale: 8! = 40320 is the largest factorial that fits in 16 bits.
- Undefined:
  - No REJ state.
  - ERR is tied to 0.
  - Any N runs and the result wraps modulo 2^16.

## Structure
- Package factorial_pkg holds:
  - state enum: IDLE, LOAD, CHECK, MULT, FIN, REJ;
  - mux select constants: MUX1_ZERO/MUX1_MUL/MUX1_ONE and MUX2_DIN/MUX2_DEC/MUX2_ZERO;
  - RES_ADDR = 1'b0, CNT_ADDR = 2'b00;
  - FACT_MAX_N = 8.
- Single module with no sub-modules. Next-state logic and output decode live in separate always blocks.

## Test plan
- N=5, START pulse → DONE at cycle 11 after the START edge; S0 = 120 (16'h0078); exactly 4 MULT cycles observed.
- N=0, then separately N=1 → DONE at cycle 3; S0 = 1; WE1 asserted only in LOAD.
- N=8 → DONE at cycle 17; S0 = 40320 (16'h9D80); ERR = 0.
- N=9:
  - macro defined → DONE=ERR=1 at cycle 1, no WE ever high;
  - macro undefined → DONE at cycle 19, S0 = 9! mod 2^16 = 16'h8980.
- N=6 with RST pulsed during the 3rd MULT → IDLE and all outputs 0 on the next edge. A new START with N=3 then gives S0 = 6 at cycle 7.
- START re-pulsed during a running N=4 job → ignored; single DONE at cycle 9; S0 = 24.

Source files
------------

// File: rtl/factorial_pkg.sv
// factorial_pkg: shared state encoding, mux selects and addresses for the factorial controller
package factorial_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, MULT, FIN, REJ} state_e;
  localparam logic [1:0] MUX1_ZERO = 2'd0;
  localparam logic [1:0] MUX1_MUL  = 2'd1;
  localparam logic [1:0] MUX1_ONE  = 2'd2;
  localparam logic [1:0] MUX2_DIN  = 2'd0;
  localparam logic [1:0] MUX2_DEC  = 2'd1;
  localparam logic [1:0] MUX2_ZERO = 2'd2;
  localparam logic       RES_ADDR  = 1'b0;
  localparam logic [1:0] CNT_ADDR  = 2'b00;
  localparam logic [15:0] FACT_MAX_N = 16'd8;
endpackage

// File: rtl/factorial_if.sv
// factorial_if: command/status and datapath-control bundle around factorial_ctrl
interface factorial_if;
  logic        start;
  logic [15:0] n_in;
  logic [15:0] sum;
  logic        we1;
  logic        we2;
  logic        wa1;
  logic [1:0]  wa2;
  logic        rea1;
  logic        rea2;
  logic [1:0]  sel_mux1;
  logic [1:0]  sel_mux2;
  logic        busy;
  logic        done;
  logic        err;
  modport master (output start, n_in, sum,
                  input  we1, we2, wa1, wa2, rea1, rea2, sel_mux1, sel_mux2, busy, done, err);
  modport slave  (input  start, n_in, sum,
                  output we1, we2, wa1, wa2, rea1, rea2, sel_mux1, sel_mux2, busy, done, err);
endinterface

// File: rtl/factorial_ctrl.sv
// factorial_ctrl: Moore FSM sequencing the 16-bit factorial datapath.
// Define FACT_OVF_CHECK_EN to reject N > FACT_MAX_N through the REJ state.
module factorial_ctrl
  import factorial_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  factorial_if.slave  bus
);
  state_e state_q, state_d;
  logic   ovf;
  logic   wr;
  logic   rd;
`ifdef FACT_OVF_CHECK_EN
  assign ovf = bus.n_in > FACT_MAX_N;
`else
  assign ovf = 1'b0;
`endif
  always_ff @(posedge CLK) begin
    state_q <= RST ? IDLE : state_d;
  end
  // SUM is S1-1: 0 means N reached 1, all-ones means N was 0
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.start ? (ovf ? REJ : LOAD) : IDLE;
      LOAD:    state_d = CHECK;
      CHECK:   state_d = (bus.sum == 16'h0000 || bus.sum == 16'hFFFF) ? FIN : MULT;
      MULT:    state_d = CHECK;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    wr           = state_q == LOAD || state_q == MULT;
    rd           = state_q == CHECK || state_q == MULT;
    bus.we1      = wr;
    bus.we2      = wr;
    bus.rea1     = rd;
    bus.rea2     = rd;
    bus.wa1      = RES_ADDR;
    bus.wa2      = CNT_ADDR;
    bus.sel_mux1 = state_q == LOAD ? MUX1_ONE : state_q == MULT ? MUX1_MUL : MUX1_ZERO;
    bus.sel_mux2 = state_q == MULT ? MUX2_DEC : MUX2_DIN;
    bus.busy     = state_q != IDLE;
    bus.done     = state_q == FIN || state_q == REJ;
`ifdef FACT_OVF_CHECK_EN
    bus.err      = state_q == REJ;
`else
    bus.err      = 1'b0;
`endif
  end
endmodule

// File: tb/tb_factorial_ctrl.sv
// tb_factorial_ctrl: directed vectors against factorial_ctrl with a behavioural datapath
module tb_factorial_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] s0 = 16'd0;
  logic [15:0] s1 = 16'd0;
  int          vectors = 0;
  int          miscompares = 0;
  factorial_if bus ();
  factorial_ctrl dut (.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.sum = s1 - 16'd1;
  // register file + multiplier + decrementer + write muxes
  always @(posedge clk) begin
    if (bus.we1) s0 <= bus.sel_mux1 == 2'd1 ? s0 * s1 : bus.sel_mux1 == 2'd2 ? 16'd1 : 16'd0;
    if (bus.we2) s1 <= bus.sel_mux2 == 2'd0 ? bus.n_in : bus.sel_mux2 == 2'd1 ? s1 - 16'd1 : 16'd0;
  end
  wire [13:0] outs = {bus.busy, bus.done, bus.err, bus.we1, bus.we2, bus.wa1, bus.wa2,
                      bus.rea1, bus.rea2, bus.sel_mux1, bus.sel_mux2};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [15:0] n, input int exp_lat, input logic [15:0] exp_s0,
                     input int exp_mult, input logic exp_err, input bit repulse);
    int lat = 0;
    int mults = 0;
    int we1n = 0;
    logic err_seen = 1'b0;
    logic we_on_done = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.n_in  = n;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 1; c <= 60 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
      if (repulse) begin
        bus.start = (c == 3 || c == 5);
        bus.n_in  = (c == 3 || c == 5) ? 16'd7 : n;
      end
      if (bus.we1) we1n++;
      if (bus.we1 && bus.sel_mux1 == 2'd1) mults++;
      if (bus.done && (bus.we1 || bus.we2)) we_on_done = 1'b1;
      if (bus.done) begin
        lat = c;
        err_seen = bus.err;
      end
    end
    bus.start = 1'b0;
    chk("latency", lat, exp_lat);
    chk("s0", {16'd0, s0}, {16'd0, exp_s0});
    chk("mult_cycles", mults, exp_mult);
    chk("we1_cycles", we1n, exp_err ? 0 : exp_mult + 1);
    chk("err", {31'd0, err_seen}, {31'd0, exp_err});
    chk("we_with_done", {31'd0, we_on_done}, 32'd0);
    @(negedge clk);
    chk("idle_after_fin", {18'd0, outs}, 32'd0);
  endtask
  initial begin
    int mults;
    bus.start = 1'b0;
    bus.n_in  = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {18'd0, outs}, 32'd0);
    rst = 1'b0;
    run(16'd5, 11, 16'h0078, 4, 1'b0, 1'b0);
    run(16'd0, 3, 16'h0001, 0, 1'b0, 1'b0);
    run(16'd1, 3, 16'h0001, 0, 1'b0, 1'b0);
    run(16'd8, 17, 16'h9D80, 7, 1'b0, 1'b0);
`ifdef FACT_OVF_CHECK_EN
    run(16'd9, 1, 16'h9D80, 0, 1'b1, 1'b0);
`else
    run(16'd9, 19, 16'h8980, 8, 1'b0, 1'b0);
`endif
    // reset mid-run during the third MULT
    @(negedge clk);
    bus.start = 1'b1;
    bus.n_in  = 16'd6;
    @(posedge clk);
    #1 bus.start = 1'b0;
    mults = 0;
    for (int c = 0; c < 40 && mults < 3; c++) begin
      @(negedge clk);
      if (bus.we1 && bus.sel_mux1 == 2'd1) mults++;
    end
    chk("third_mult_reached", mults, 3);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("rst_midrun_outputs", {18'd0, outs}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run(16'd3, 7, 16'h0006, 2, 1'b0, 1'b0);
    run(16'd4, 9, 16'h0018, 3, 1'b0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
